// File: rtl/capture_playback_ctrl.sv
// Purpose: capture a triggered burst of samples into an SDP block RAM, then play it back in order.
// Latency: a sample reaches the RAM write port one cycle after acceptance; playback data appears two cycles after a read issues.
// Backpressure: none on the sample input; the playback side obeys m_ready via a 2-entry skid buffer and read throttling.
module capture_playback_ctrl #(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arm,
  input  logic [AW-1:0] cap_len,
  input  logic          trig,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  input  logic          m_ready,
  output logic          busy,
  output logic          done,
  output logic          ram_cea,
  output logic [AW-1:0] ram_ada,
  output logic [DW-1:0] ram_din,
  output logic          ram_ceb,
  output logic [AW-1:0] ram_adb,
  output logic          ram_oce,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_CAPTURE, S_FLUSH, S_DRAIN, S_DONE
  } state_t;

  state_t state_q, state_d;

  // Counters carry one extra bit so a full 2^AW burst terminates without wrapping.
  logic [AW:0] len_q, wr_cnt_q, rd_cnt_q, wr_nxt, rd_nxt;
  logic        ceb_last_q, dout_vld_q, dout_last_q;
  logic [1:0]  occ_q, occ_d;
  logic [DW:0] skid0_q, skid1_q, skid0_d, skid1_d;   // {last, data}
  logic        accept, issue, pop, pop_skid, push, head_last;
  logic [2:0]  inflight_sum;

  assign wr_nxt = wr_cnt_q + {{AW{1'b0}}, 1'b1};
  assign rd_nxt = rd_cnt_q + {{AW{1'b0}}, 1'b1};

  // Handshake, throttling and status decode; the RAM output acts as the head entry when the skid is empty.
  always_comb begin
    m_valid      = 1'b0;
    m_data       = '0;
    head_last    = 1'b0;
    busy         = (state_q != S_IDLE);
    done         = (state_q == S_DONE);
    ram_oce      = 1'b1;
    if (occ_q != 2'd0) begin
      m_data    = skid0_q[DW-1:0];
      head_last = skid0_q[DW];
    end else if (dout_vld_q) begin
      m_data    = ram_dout;
      head_last = dout_last_q;
    end
    m_valid      = (state_q == S_DRAIN) && ((occ_q != 2'd0) || dout_vld_q);
    m_last       = m_valid && head_last;
    pop          = m_valid && m_ready;
    pop_skid     = pop && (occ_q != 2'd0);
    push         = dout_vld_q && !(pop && (occ_q == 2'd0));
    accept       = s_valid && (((state_q == S_ARMED) && trig) || (state_q == S_CAPTURE));
    inflight_sum = {1'b0, occ_q} + {2'b00, ram_ceb} + {2'b00, dout_vld_q};
    issue        = (state_q == S_DRAIN) && (rd_cnt_q < len_q) &&
                   (inflight_sum < (pop ? 3'd3 : 3'd2));
  end

  // Next-state logic for the capture/playback sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (arm) state_d = S_ARMED;
      S_ARMED:   if (trig) state_d = (accept && (wr_nxt == len_q)) ? S_FLUSH : S_CAPTURE;
      S_CAPTURE: if (accept && (wr_nxt == len_q)) state_d = S_FLUSH;
      S_FLUSH:   state_d = S_DRAIN;
      S_DRAIN:   if (pop && head_last) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Skid buffer update: pop the head first, then append the RAM word unless it was consumed directly.
  always_comb begin
    occ_d   = occ_q;
    skid0_d = skid0_q;
    skid1_d = skid1_q;
    if (pop_skid) begin
      skid0_d = skid1_q;
      occ_d   = occ_q - 2'd1;
    end
    if (push) begin
      if (occ_d == 2'd0) skid0_d = {dout_last_q, ram_dout};
      else               skid1_d = {dout_last_q, ram_dout};
      occ_d = occ_d + 2'd1;
    end
  end

  // Registered RAM ports, burst counters and read pipeline tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q       <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      ram_cea     <= 1'b0;
      ram_ada     <= '0;
      ram_din     <= '0;
      ram_ceb     <= 1'b0;
      ram_adb     <= '0;
      ceb_last_q  <= 1'b0;
      dout_vld_q  <= 1'b0;
      dout_last_q <= 1'b0;
      occ_q       <= '0;
      skid0_q     <= '0;
      skid1_q     <= '0;
    end else begin
      ram_cea <= accept;
      if (accept) begin
        ram_ada  <= wr_cnt_q[AW-1:0];
        ram_din  <= s_data;
        wr_cnt_q <= wr_nxt;
      end
      if ((state_q == S_IDLE) && arm) begin
        len_q    <= (cap_len == '0) ? {1'b1, {AW{1'b0}}} : {1'b0, cap_len};
        wr_cnt_q <= '0;
        rd_cnt_q <= '0;
      end
      ram_ceb <= issue;
      if (issue) begin
        ram_adb    <= rd_cnt_q[AW-1:0];
        ceb_last_q <= (rd_nxt == len_q);
        rd_cnt_q   <= rd_nxt;
      end
      dout_vld_q  <= ram_ceb;
      dout_last_q <= ram_ceb && ceb_last_q;
      occ_q       <= occ_d;
      skid0_q     <= skid0_d;
      skid1_q     <= skid1_d;
    end
  end

endmodule

// File: tb/tb_capture_playback_ctrl.sv
// Bench for capture_playback_ctrl: behavioural SDP RAM, table of capture/playback cases,
// scoreboard of expected beats filled as samples are driven, plus hand-written corner sequences.
module tb_capture_playback_ctrl;
  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          arm = 1'b0;
  logic [AW-1:0] cap_len = '0;
  logic          trig = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          m_valid, m_last, busy, done;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b1;
  logic          ram_cea, ram_ceb, ram_oce;
  logic [AW-1:0] ram_ada, ram_adb;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = '0;

  always #5 clk = ~clk;

  capture_playback_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .arm(arm), .cap_len(cap_len), .trig(trig),
    .s_valid(s_valid), .s_data(s_data), .m_valid(m_valid), .m_data(m_data),
    .m_last(m_last), .m_ready(m_ready), .busy(busy), .done(done),
    .ram_cea(ram_cea), .ram_ada(ram_ada), .ram_din(ram_din), .ram_ceb(ram_ceb),
    .ram_adb(ram_adb), .ram_oce(ram_oce), .ram_dout(ram_dout)
  );

  // Behavioural 4096x16 SDP RAM, bypass mode, one-cycle read latency.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_cea) mem[ram_ada] <= ram_din;
    if (ram_ceb) ram_dout <= mem[ram_adb];
  end

  int tests = 0;
  int failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name, input string detail);
    tests++;
    failed++;
    $display("FAIL %s: %s", name, detail);
  endtask

  // Scoreboard of {last, data} expected on the playback port.
  logic [DW:0] sb [$];

  int beat_cnt = 0, done_cnt = 0, cea_cnt = 0, coll_cnt = 0, vld_idle_cnt = 0;
  logic [DW-1:0] first_dat = '0, last_dat = '0, prev_dat = '0;
  logic prev_hold = 1'b0, prev_last = 1'b0;
  logic [DW:0] exp_beat;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (prev_hold) begin
      check("hold_valid", 32'(m_valid), 32'd1);
      check("hold_data", 32'(m_data), 32'(prev_dat));
      check("hold_last", 32'(m_last), 32'(prev_last));
    end
    prev_hold = m_valid && !m_ready && !reset;
    prev_dat  = m_data;
    prev_last = m_last;
    if (!reset) begin
      if (done) done_cnt++;
      if (ram_cea) cea_cnt++;
      if (ram_cea && ram_ceb) coll_cnt++;
      if (m_valid && !busy) vld_idle_cnt++;
      if (m_valid && m_ready) begin
        if (beat_cnt == 0) first_dat = m_data;
        if (m_last) last_dat = m_data;
        beat_cnt++;
        if (sb.size() == 0) begin
          fail_msg("sb_extra_beat", $sformatf("got beat data 0x%0h last %0d, expected no beat", m_data, m_last));
        end else begin
          exp_beat = sb.pop_front();
          check("beat_data", 32'(m_data), 32'(exp_beat[DW-1:0]));
          check("beat_last", 32'(m_last), 32'(exp_beat[DW]));
        end
      end
    end
  end

  // Downstream ready pattern: 0 always ready, 1 random, 2 random with long stalls, 3 driven by hand.
  int rmode = 0;
  int stall = 0;
  always @(posedge clk) begin
    #1;
    case (rmode)
      0: m_ready = 1'b1;
      1: m_ready = 1'($urandom_range(0, 1));
      2: begin
        if (stall > 0) begin
          m_ready = 1'b0;
          stall--;
        end else if ($urandom_range(0, 7) == 0) begin
          m_ready = 1'b0;
          stall = $urandom_range(5, 20);
        end else begin
          m_ready = 1'($urandom_range(0, 1));
        end
      end
      default: ;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    beat_cnt = 0;
    done_cnt = 0;
    cea_cnt  = 0;
    first_dat = '0;
    last_dat  = '0;
  endtask

  task automatic wait_finish(input string tag, input int exp_beats, input logic [DW-1:0] exp_first,
                             input logic [DW-1:0] exp_last, input int budget);
    bit seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      fail_msg({tag, "_done_timeout"}, $sformatf("no done within %0d cycles, %0d beats seen", budget, beat_cnt));
      sb.delete();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    check({tag, "_beats"}, 32'(beat_cnt), 32'(exp_beats));
    check({tag, "_first"}, 32'(first_dat), 32'(exp_first));
    check({tag, "_last"}, 32'(last_dat), 32'(exp_last));
    check({tag, "_writes"}, 32'(cea_cnt), 32'(exp_beats));
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  typedef struct {
    logic [AW-1:0] cap_len;
    int            n_pre;
    int            gap;
    int            rmode;
    logic [DW-1:0] base;
    logic [DW-1:0] stride;
    int            exp_beats;
    logic [DW-1:0] exp_first;
    logic [DW-1:0] exp_last;
  } vec_t;

  task automatic run_case(input vec_t v, input string tag);
    int eff, k, cyc;
    rmode = v.rmode;
    clear_counts();
    arm = 1'b1;
    cap_len = v.cap_len;
    tick();
    arm = 1'b0;
    check({tag, "_busy_armed"}, 32'(busy), 32'd1);
    for (int i = 0; i < v.n_pre; i++) begin
      s_valid = 1'b1;
      s_data  = 16'hDEA0 + DW'(i);
      tick();
    end
    eff = (v.cap_len == '0) ? (1 << AW) : int'(v.cap_len);
    k = 0;
    cyc = 0;
    while (k < eff) begin
      trig = (cyc == 0);
      if (v.gap != 0 && (cyc % v.gap) == v.gap - 1) begin
        s_valid = 1'b0;
      end else begin
        s_valid = 1'b1;
        s_data  = v.base + DW'(k) * v.stride;
        sb.push_back({(k == eff - 1), s_data});
        k++;
      end
      tick();
      cyc++;
    end
    trig = 1'b0;
    s_valid = 1'b1;
    s_data = 16'hBAD0;
    tick();
    s_data = 16'hBAD1;
    tick();
    s_valid = 1'b0;
    wait_finish(tag, v.exp_beats, v.exp_first, v.exp_last, eff * 64 + 200);
  endtask

  vec_t vecs [6];
  vec_t v_after;

  initial begin
    vecs[0] = '{12'd4, 0, 0, 0, 16'h1111, 16'h1111, 4,    16'h1111, 16'h4444};
    vecs[1] = '{12'd8, 0, 0, 2, 16'h0A00, 16'h0003, 8,    16'h0A00, 16'h0A15};
    vecs[2] = '{12'd6, 3, 3, 1, 16'h5000, 16'h0010, 6,    16'h5000, 16'h5050};
    vecs[3] = '{12'd1, 2, 0, 1, 16'hBEEF, 16'h0000, 1,    16'hBEEF, 16'hBEEF};
    vecs[4] = '{12'd0, 0, 0, 0, 16'h0000, 16'h0001, 4096, 16'h0000, 16'h0FFF};
    vecs[5] = '{12'd5, 1, 2, 2, 16'h0007, 16'h0101, 5,    16'h0007, 16'h040B};

    // Reset state.
    reset = 1'b1;
    tick();
    tick();
    tick();
    @(negedge clk);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ram_cea", 32'(ram_cea), 32'd0);
    check("rst_ram_ceb", 32'(ram_ceb), 32'd0);
    check("rst_ram_ada", 32'(ram_ada), 32'd0);
    check("rst_ram_adb", 32'(ram_adb), 32'd0);
    check("rst_ram_din", 32'(ram_din), 32'd0);
    check("rst_ram_oce", 32'(ram_oce), 32'd1);
    tick();
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_case(vecs[i], $sformatf("vec%0d", i));

    // arm and trig together in IDLE: only the arm counts, trig must come again.
    rmode = 0;
    clear_counts();
    arm = 1'b1;
    cap_len = 12'd1;
    trig = 1'b1;
    s_valid = 1'b1;
    s_data = 16'h9999;
    tick();
    arm = 1'b0;
    trig = 1'b0;
    s_data = 16'h8888;
    tick();
    tick();
    tick();
    check("armtrig_busy", 32'(busy), 32'd1);
    check("armtrig_no_write", 32'(cea_cnt), 32'd0);
    trig = 1'b1;
    s_data = 16'h1234;
    sb.push_back({1'b1, 16'h1234});
    tick();
    trig = 1'b0;
    s_valid = 1'b0;
    wait_finish("armtrig", 1, 16'h1234, 16'h1234, 200);

    // Reset in the middle of playback after two of six beats.
    rmode = 3;
    m_ready = 1'b1;
    clear_counts();
    arm = 1'b1;
    cap_len = 12'd6;
    tick();
    arm = 1'b0;
    for (int k = 0; k < 6; k++) begin
      trig = (k == 0);
      s_valid = 1'b1;
      s_data = 16'h0600 + DW'(k);
      sb.push_back({(k == 5), s_data});
      tick();
    end
    trig = 1'b0;
    s_valid = 1'b0;
    begin
      bit hit = 1'b0;
      for (int c = 0; c < 200 && !hit; c++) begin
        tick();
        if (beat_cnt >= 2) begin
          m_ready = 1'b0;
          reset = 1'b1;
          hit = 1'b1;
        end
      end
      if (!hit) begin
        fail_msg("midreset_reach", $sformatf("only %0d beats before bound, expected 2", beat_cnt));
        reset = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("midreset_beats", 32'(beat_cnt), 32'd2);
    check("midreset_m_valid", 32'(m_valid), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    tick();
    reset = 1'b0;
    sb.delete();
    tick();
    v_after = '{12'd3, 0, 0, 1, 16'h3A00, 16'h0007, 3, 16'h3A00, 16'h3A0E};
    run_case(v_after, "after_reset");

    check("no_rw_collision", 32'(coll_cnt), 32'd0);
    check("valid_only_when_busy", 32'(vld_idle_cnt), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Global bound on run time.
  initial begin
    #5000000;
    fail_msg("global_timeout", "simulation exceeded 5 ms, expected completion well before");
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/capture_playback_ctrl.md
Name: capture_playback_ctrl

Overview:
- Controls one 4096x16 simple dual-port block RAM (SDPB, bypass read mode, 1-cycle read latency).
- Captures a triggered burst of 16-bit samples into the RAM through its write port.
- Plays the burst back in order to a downstream consumer with a valid/ready handshake.
- Sits between the sample source and the 4096-entry buffer on its write side, and drives the read side toward the tracking logic.

Parameters:
- AW, 12, RAM address width; depth is 2^AW.
- DW, 16, sample/data width.

Ports:
- clk  in  1  single system clock; also drives both RAM clocks.
- reset  in  1  synchronous, active-high reset.
- arm  in  1  one-cycle pulse that starts a capture; honoured only in IDLE.
- cap_len  in  AW  number of samples to capture; latched on arm; 0 means 2^AW.
- trig  in  1  capture trigger; sampled only in ARMED.
- s_valid  in  1  input sample strobe; no backpressure.
- s_data  in  DW  input sample.
- m_valid  out  1  playback data valid.
- m_data  out  DW  playback sample.
- m_last  out  1  high with the final playback sample.
- m_ready  in  1  downstream accept.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last playback handshake.
- ram_cea  out  1  RAM write enable.
- ram_ada  out  AW  RAM write address.
- ram_din  out  DW  RAM write data.
- ram_ceb  out  1  RAM read enable.
- ram_adb  out  AW  RAM read address.
- ram_oce  out  1  RAM output enable; constant 1.
- ram_dout  in  DW  RAM read data, valid the cycle after a ram_ceb edge.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high.
- Reset value of all outputs is 0, except ram_oce=1. Reset sets state=IDLE and clears all counters and the skid buffer.
- Reset asserted in any state aborts the operation. Subsequent RAM contents are don't-care.

State machine (IDLE, ARMED, CAPTURE, FLUSH, DRAIN, DONE):
- IDLE:
  - arm=1: latch len = (cap_len==0 ? 2^AW : cap_len), clear wr_cnt, go to ARMED.
  - trig and s_valid are ignored.
- ARMED:
  - In the cycle trig=1, go to CAPTURE. If s_valid=1 in that same cycle, that sample is the first captured one.
  - arm is ignored.
- CAPTURE:
  - Each accepted sample registers ram_cea=1, ram_ada=wr_cnt, ram_din=s_data for the next cycle, then wr_cnt++.
  - When the len-th sample is accepted, go to FLUSH.
  - s_valid after the len-th sample is dropped.
- FLUSH:
  - One cycle while the last registered write commits.
  - ram_cea is 0 afterwards.
  - Guarantees no read issues on the same edge as a write.
- DRAIN:
  - Reads addresses 0..len-1 in order via ram_ceb/ram_adb, registered.
  - Uses a 2-entry output skid buffer; head entry drives m_valid/m_data/m_last.
  - A read issues only when (occupancy + in-flight reads − pop this cycle) < 2. This guarantees no data loss under any m_ready pattern.
  - With m_ready held at 1, throughput is one sample per cycle after the initial 2-cycle latency (read issue, then RAM output).
  - m_last=1 exactly on the sample from address len-1.
  - On the handshake (m_valid & m_ready) of the last sample, go to DONE.
- DONE: done=1 for one cycle, then return to IDLE.

Handshake rules:
- Once m_valid=1, m_valid, m_data and m_last hold stable until m_ready=1.
- m_valid is never 1 outside DRAIN.

Address and width rules:
- Address counters are AW bits. len=2^AW requires a counter of AW+1 bits so that the final address 2^AW−1 terminates correctly without wrapping to 0.

Boundary cases:
- len=1: one write, FLUSH, one read, one m_valid with m_last=1.
- arm and trig high in the same cycle in IDLE: only the arm takes effect. trig must be seen again in ARMED.

Test Plan:
- arm with cap_len=4; trig with s_data=0x1111 and s_valid high; then 0x2222, 0x3333, 0x4444; m_ready=1 → m_data sequence 0x1111, 0x2222, 0x3333, 0x4444; m_last only on 0x4444; done pulses once; busy falls to 0.
- cap_len=0, 4096 ramp samples 0..4095 → 4096 outputs equal to 0..4095; m_last on 4095; address wraps correctly; no extra beat.
- cap_len=8, m_ready toggling at random (including long stalls) → all 8 values delivered in order; no duplicates or drops; m_data stable while m_valid & !m_ready.
- s_valid gaps during CAPTURE plus s_valid in ARMED before trig → pre-trigger samples absent from playback; gaps do not insert entries.
- reset asserted mid-DRAIN (after 2 of 6 samples) → next cycle m_valid=0 and busy=0; a new arm/capture of 3 samples plays back correctly.
- cap_len=1; arm and trig in the same cycle in IDLE → no capture until trig is reasserted; then a single beat with m_last=1.
